// File: rtl/pipe_stage_reg.sv
// Two-entry elastic pipeline register (output + skid) with flush, bubble-zeroed
// control fields and a saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RW_W   = 5,
  parameter int unsigned M_W    = 2,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [M_W-1:0]    M_control_in,
  input  logic [WB_W-1:0]   WB_control_in,
  input  logic [DATA_W-1:0] ALU_out_in,
  input  logic [DATA_W-1:0] data_write_in,
  input  logic [RW_W-1:0]   rw_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M_W-1:0]    M_control_out,
  output logic [WB_W-1:0]   WB_control_out,
  output logic [DATA_W-1:0] ALU_out_out,
  output logic [DATA_W-1:0] data_write_out,
  output logic [RW_W-1:0]   rw_out,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int unsigned P_W = M_W + WB_W + 2 * DATA_W + RW_W;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state_q, state_d;
  logic             ready_q;
  logic             accept, emit;
  logic             load_out, load_skid, out_from_skid;
  logic [P_W-1:0]   in_pay, out_pay, skid_pay;
  logic [M_W-1:0]   m_held;
  logic [WB_W-1:0]  wb_held;

  assign in_pay = {M_control_in, WB_control_in, ALU_out_in, data_write_in, rw_in};

  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = ready_q;
    accept    = in_valid & ready_q;
    emit      = out_valid & out_ready;
  end

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d  = ONE;
          load_out = 1'b1;
        end
        ONE: begin
          if (accept && emit) begin
            load_out = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        FULL: if (emit) begin
          state_d       = ONE;
          load_out      = 1'b1;
          out_from_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready is registered from next-state so out_ready never reaches it combinationally
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_pay  <= '0;
      skid_pay <= '0;
    end else begin
      if (load_out)  out_pay  <= out_from_skid ? skid_pay : in_pay;
      if (load_skid) skid_pay <= in_pay;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  always_comb begin
    {m_held, wb_held, ALU_out_out, data_write_out, rw_out} = out_pay;
    M_control_out  = out_valid ? m_held  : '0;
    WB_control_out = out_valid ? wb_held : '0;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every negedge,
// plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MAXC = '1;

  typedef struct packed {
    logic [1:0]  m;
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [31:0] dw;
    logic [4:0]  rw;
  } ent_t;

  logic        clock, reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  M_control_out, WB_control_out;
  logic [31:0] ALU_out_out, data_write_out;
  logic [4:0]  rw_out;
  logic [CNT_W-1:0] stall_count;
  ent_t din;

  int compared = 0;
  int mismatched = 0;

  pipe_stage_reg #(.DATA_W(32), .RW_W(5), .M_W(2), .WB_W(2), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .M_control_in(din.m), .WB_control_in(din.wb), .ALU_out_in(din.alu),
    .data_write_in(din.dw), .rw_in(din.rw),
    .out_valid(out_valid), .out_ready(out_ready),
    .M_control_out(M_control_out), .WB_control_out(WB_control_out),
    .ALU_out_out(ALU_out_out), .data_write_out(data_write_out), .rw_out(rw_out),
    .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: the held entries as an ordered queue of at most two
  ent_t q[$];
  ent_t m_last;
  logic m_rdy;
  logic [CNT_W-1:0] m_stall;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_last  = '0;
      m_rdy   = 1'b0;
      m_stall = '0;
    end else begin
      logic acc, emt;
      acc = in_valid && m_rdy && (q.size() < 2);
      emt = (q.size() > 0) && out_ready;
      if ((q.size() > 0) && !out_ready && (m_stall != MAXC)) m_stall = m_stall + 1'b1;
      if (flush) q.delete();
      else begin
        if (emt) void'(q.pop_front());
        if (acc) q.push_back(din);
      end
      if (q.size() > 0) m_last = q[0];
      m_rdy = 1'b1;
    end
  end

  always @(negedge clock) begin
    ent_t e;
    logic [79:0] act, exp;
    logic ev;
    ev = (q.size() > 0);
    e  = ev ? q[0] : m_last;
    if (!ev) begin
      e.m  = '0;
      e.wb = '0;
    end
    exp = {ev, m_rdy && (q.size() < 2), e.m, e.wb, e.alu, e.dw, e.rw, m_stall};
    act = {out_valid, in_ready, M_control_out, WB_control_out, ALU_out_out,
           data_write_out, rw_out, stall_count};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act, exp);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] a);
    ent_t e;
    e.m   = a[1:0] | 2'b01;
    e.wb  = a[3:2] ^ 2'b10;
    e.alu = a;
    e.dw  = a ^ 32'hA5A5_0000;
    e.rw  = a[4:0];
    return e;
  endfunction

  // Apply inputs for exactly one rising edge, returning at edge+1
  task automatic step(input logic v, input logic r, input logic f, input logic [31:0] a);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    din       = mk(a);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; din = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    reset_n = 1'b1;
    step(0, 1, 0, 0);
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Stream at full rate
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, 0, 32'(i));
      chk("stream_alu", ALU_out_out, 32'(i));
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    step(0, 1, 0, 0);
    chk("stream_drain_valid", 32'(out_valid), 32'd0);
    chk("bubble_m", 32'(M_control_out), 32'd0);

    // Back-pressure: A held, B in skid, C refused
    step(1, 0, 0, 32'hA);
    step(1, 0, 0, 32'hB);
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    step(1, 0, 0, 32'hC);
    chk("bp_hold_a", ALU_out_out, 32'hA);
    step(1, 1, 0, 32'hC);
    chk("bp_emit_b", ALU_out_out, 32'hB);
    step(1, 1, 0, 32'hC);
    chk("bp_emit_c", ALU_out_out, 32'hC);
    step(0, 1, 0, 0);
    chk("bp_stall", 32'(stall_count), 32'd2);

    // Flush while FULL with a word offered
    step(1, 0, 0, 32'h11);
    step(1, 0, 0, 32'h22);
    step(1, 0, 1, 32'h33);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_wb", 32'(WB_control_out), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_stall", 32'(stall_count), 32'd4);
    step(0, 1, 0, 0);
    chk("flush_lost", 32'(out_valid), 32'd0);
    chk("flush_hold_alu", ALU_out_out, 32'h11);

    // Counter saturation
    step(1, 0, 0, 32'h44);
    repeat (20) step(0, 0, 0, 0);
    chk("sat_stall", 32'(stall_count), 32'd15);

    // Asynchronous reset between edges while FULL
    step(1, 0, 0, 32'h55);
    chk("pre_rst_ready", 32'(in_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    chk("arst_alu", ALU_out_out, 32'd0);
    chk("arst_stall", 32'(stall_count), 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    step(0, 1, 0, 0);
    chk("arst_fresh_ready", 32'(in_ready), 32'd1);
    step(1, 1, 0, 32'h66);
    chk("arst_fresh_alu", ALU_out_out, 32'h66);

    // Random traffic against the queue model
    for (int n = 0; n < 10000; n++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0, $urandom);
    end
    repeat (3) step(0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL provide parameter DATA_W, default 32: width of alu_out and data_write fields.
REQ-002 The block SHALL provide parameter RW_W, default 5: width of the destination register field.
REQ-003 The block SHALL provide parameters M_W and WB_W, default 2 each: widths of the memory and write-back control fields.
REQ-004 The block SHALL provide parameter CNT_W, default 16: width of the stall counter.

Ports (name, direction, width, meaning):
REQ-005 clock, in, 1: single clock; all state changes on its rising edge.
REQ-006 reset_n, in, 1: reset, asynchronous assert, active-low.
REQ-007 flush, in, 1: synchronous kill of all held entries.
REQ-008 in_valid, in, 1 and in_ready, out, 1: upstream handshake.
REQ-009 M_control_in, in, M_W; WB_control_in, in, WB_W; ALU_out_in, in, DATA_W; data_write_in, in, DATA_W; rw_in, in, RW_W: upstream payload.
REQ-010 out_valid, out, 1 and out_ready, in, 1: downstream handshake.
REQ-011 M_control_out, WB_control_out, ALU_out_out, data_write_out, rw_out, out, widths as inputs: downstream payload.
REQ-012 stall_count, out, CNT_W: count of back-pressured cycles.

Function
REQ-013 Storage SHALL be two entries: output register (drives *_out) and skid register; each has its own valid bit.
REQ-014 Occupancy states SHALL be EMPTY (out_valid=0), ONE (out_valid=1, skid empty), FULL (both valid).
REQ-015 in_ready SHALL equal NOT skid_valid, registered-state only: no combinational path from out_ready to in_ready.
REQ-016 Accept SHALL occur when in_valid AND in_ready; emit SHALL occur when out_valid AND out_ready.
REQ-017 EMPTY + accept -> ONE, payload in output register; latency one cycle from accept edge to out_valid=1.
REQ-018 ONE + accept + emit -> ONE, new payload replaces output register.
REQ-019 ONE + accept, no emit -> FULL, payload captured in skid register.
REQ-020 ONE + emit, no accept -> EMPTY.
REQ-021 FULL + emit -> ONE, skid payload moves to output register; no accept is possible in FULL.
REQ-022 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated except by flush.
REQ-023 Payload registers SHALL hold their value while not loaded (stall).
REQ-024 flush SHALL take priority over accept and emit: next state EMPTY, and any entry accepted in the flush cycle is discarded.
REQ-025 Whenever out_valid=0, M_control_out and WB_control_out SHALL be zero (bubble); ALU_out_out, data_write_out, and rw_out are don't-care but SHALL hold their last value.
REQ-026 stall_count SHALL increment by 1 on each cycle with out_valid=1 AND out_ready=0, including flush cycles; it SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-027 All arithmetic SHALL be unsigned; no payload field is modified in transit.

Reset
REQ-028 While reset_n=0, the block SHALL hold out_valid=0, skid_valid=0, in_ready=0, all *_out=0, and stall_count=0, asynchronously.
REQ-029 On the first rising clock edge after reset_n rises, in_ready SHALL be 1, and the state SHALL be EMPTY.
REQ-030 Reset asserted mid-transfer SHALL discard both entries, with no output glitch to valid.

Verification
REQ-031 Stream: in_valid=1 for 4 cycles with ALU_out_in=1,2,3,4 and out_ready=1 -> out_valid from cycle 1, out values 1,2,3,4 consecutive, in_ready constantly 1.
REQ-032 Back-pressure: out_ready=0 with 3 offered words A,B,C -> A held on output, B in skid, in_ready=0, C not accepted. Then out_ready=1 -> A, B, C emitted in order, and stall_count advances once per stalled cycle.
REQ-033 Flush in FULL, with simultaneous in_valid=1 -> next cycle out_valid=0, M/WB_control_out=0, in_ready=1, and the offered word is lost.
REQ-034 Saturation: CNT_W=4, out_ready=0 held for 20 cycles with out_valid=1 -> stall_count stops at 15.
REQ-035 Async reset asserted between edges while FULL -> outputs zero immediately, before the next clock edge. After release, behaviour matches a fresh EMPTY state.
REQ-036 Random valid/ready/flush for 10k cycles against a reference queue model -> no reorder, loss, or duplication outside flush.
